// File: rtl/weight_bram_reader_if.sv
// -----------------------------------------------------------------------------
// weight_bram_reader_if
// Groups the signals between the weight BRAM read controller and its
// surroundings: pass control (start/busy/done), the BRAM read port
// (addr/en/we/do) and the valid/ready weight stream (data/valid/ready/last).
//   master : the reader itself (drives busy/done, BRAM controls, stream)
//   slave  : the environment (drives start, BRAM data-out, stream ready)
// Optional macro WEIGHT_RD_CHECKSUM_EN adds the running checksum signal.
// -----------------------------------------------------------------------------
interface weight_bram_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic              bram_we;
    logic [DATA_W-1:0] bram_do;
    logic [DATA_W-1:0] w_data;
    logic              w_valid;
    logic              w_ready;
    logic              w_last;
`ifdef WEIGHT_RD_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport master (
        input  start, bram_do, w_ready,
`ifdef WEIGHT_RD_CHECKSUM_EN
        output checksum,
`endif
        output busy, done, bram_addr, bram_en, bram_we, w_data, w_valid, w_last
    );

    modport slave (
        output start, bram_do, w_ready,
`ifdef WEIGHT_RD_CHECKSUM_EN
        input  checksum,
`endif
        input  busy, done, bram_addr, bram_en, bram_we, w_data, w_valid, w_last
    );
endinterface

// File: rtl/weight_bram_reader.sv
// -----------------------------------------------------------------------------
// weight_bram_reader
// Streams DEPTH words out of a single-port, falling-edge-read weight BRAM as a
// valid/ready stream with LAST. A pass is launched by START in IDLE; reads are
// issued for addresses 0..DEPTH-1 and each read's data (available after the
// falling edge of the issuing cycle) is pushed into a 2-entry skid FIFO at the
// next rising edge, which lets the stream run at one word per cycle while
// still tolerating backpressure.
// Ports:
//   clk_i   : clock, all state on the rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : weight_bram_reader_if.master (start/busy/done, BRAM port, stream)
// Optional feature: define WEIGHT_RD_CHECKSUM_EN to add bus.checksum, the
// modulo-2^DATA_W sum of the words handshaked in the current pass.
// -----------------------------------------------------------------------------
module weight_bram_reader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    weight_bram_reader_if.master   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              en_q, en_d;          // also the in-flight flag: data lands at the next edge
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  del_cnt_q, del_cnt_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              head_vld_q, head_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic              last_q, last_d;
    logic              pop_s, push_s, start_ok_s;
    logic [1:0]        occ_next_s;

    assign pop_s  = head_vld_q & bus.w_ready;
    assign push_s = en_q;
    // Occupancy after this edge; the issue rule keeps occupancy + in-flight <= 2.
    assign occ_next_s = {1'b0, head_vld_q} + {1'b0, skid_vld_q} + {1'b0, en_q} - {1'b0, pop_s};

    // Pass FSM and read-issue control.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        en_d        = 1'b0;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        start_ok_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !done_q) begin
                    start_ok_s  = 1'b1;
                    busy_d      = 1'b1;
                    en_d        = 1'b1;
                    addr_d      = {ADDR_W{1'b0}};
                    issue_cnt_d = CNT_W'(1);
                    state_d     = (DEPTH == 1) ? ST_DRAIN : ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if ((issue_cnt_q < CNT_W'(DEPTH)) && (occ_next_s < 2'd2)) begin
                    en_d        = 1'b1;
                    addr_d      = ADDR_W'(issue_cnt_q);
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (issue_cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (pop_s && last_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Two-entry skid FIFO: head feeds the stream, skid catches one extra word.
    always_comb begin
        head_data_d = head_data_q;
        head_vld_d  = head_vld_q;
        skid_data_d = skid_data_q;
        skid_vld_d  = skid_vld_q;
        if (pop_s) begin
            if (skid_vld_q) begin
                head_data_d = skid_data_q;
                head_vld_d  = 1'b1;
                if (push_s) begin
                    skid_data_d = bus.bram_do;
                    skid_vld_d  = 1'b1;
                end else begin
                    skid_vld_d  = 1'b0;
                end
            end else if (push_s) begin
                head_data_d = bus.bram_do;
                head_vld_d  = 1'b1;
            end else begin
                head_vld_d  = 1'b0;
            end
        end else if (push_s) begin
            if (head_vld_q) begin
                skid_data_d = bus.bram_do;
                skid_vld_d  = 1'b1;
            end else begin
                head_data_d = bus.bram_do;
                head_vld_d  = 1'b1;
            end
        end else begin
            head_vld_d = head_vld_q;
        end
    end

    // Delivered counter; the head word's index always equals words delivered so far.
    always_comb begin
        if (start_ok_s) begin
            del_cnt_d = {CNT_W{1'b0}};
        end else if (pop_s) begin
            del_cnt_d = del_cnt_q + CNT_W'(1);
        end else begin
            del_cnt_d = del_cnt_q;
        end
        last_d = head_vld_d && (del_cnt_d == CNT_W'(DEPTH - 1));
    end

    // State, FIFO and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            issue_cnt_q <= {CNT_W{1'b0}};
            del_cnt_q   <= {CNT_W{1'b0}};
            head_data_q <= {DATA_W{1'b0}};
            skid_data_q <= {DATA_W{1'b0}};
            head_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            del_cnt_q   <= del_cnt_d;
            head_data_q <= head_data_d;
            skid_data_q <= skid_data_d;
            head_vld_q  <= head_vld_d;
            skid_vld_q  <= skid_vld_d;
            last_q      <= last_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_en   = en_q;
    assign bus.bram_we   = 1'b0;
    assign bus.w_data    = head_data_q;
    assign bus.w_valid   = head_vld_q;
    assign bus.w_last    = last_q;

`ifdef WEIGHT_RD_CHECKSUM_EN
    logic [DATA_W-1:0] cks_q, cks_d;

    // Running sum of handshaked words, restarted by each accepted START.
    always_comb begin
        if (start_ok_s) begin
            cks_d = {DATA_W{1'b0}};
        end else if (pop_s) begin
            cks_d = cks_q + head_data_q;
        end else begin
            cks_d = cks_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cks_q <= {DATA_W{1'b0}};
        end else begin
            cks_q <= cks_d;
        end
    end

    assign bus.checksum = cks_q;
`endif

    weight_bram_reader_chk u_chk (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_s),
        .full_i  (head_vld_q & skid_vld_q)
    );
endmodule

// Design-error checks for the skid FIFO.
module weight_bram_reader_chk (
    input logic clk_i,
    input logic rst_n_i,
    input logic push_i,
    input logic full_i
);
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push_i && full_i));
endmodule

// File: tb/tb_weight_bram_reader.sv
module tb_weight_bram_reader;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 28;
    localparam int ADDR_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    weight_bram_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    weight_bram_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.master)
    );

    // Behavioural BRAM: data for the addressed word appears after the falling edge.
    logic [DATA_W-1:0] mem [32];
    always @(negedge clk) begin
        if (bus.bram_en && !bus.bram_we) bus.bram_do <= mem[bus.bram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done"},  32'(bus.done),      32'd0);
        chk({tag, "_en"},    32'(bus.bram_en),   32'd0);
        chk({tag, "_addr"},  32'(bus.bram_addr), 32'd0);
        chk({tag, "_we"},    32'(bus.bram_we),   32'd0);
        chk({tag, "_valid"}, 32'(bus.w_valid),   32'd0);
        chk({tag, "_data"},  32'(bus.w_data),    32'd0);
        chk({tag, "_last"},  32'(bus.w_last),    32'd0);
`ifdef WEIGHT_RD_CHECKSUM_EN
        chk({tag, "_cks"},   32'(bus.checksum),  32'd0);
`endif
    endtask

    // mode 0: ready always, timing checked; 1: alternating ready + stray STARTs;
    // 2: random ready; 3: ten-cycle stall on word 5. abort_at >= 0 resets mid-pass.
    task automatic run_pass(input int mode, input int abort_at);
        int t, got, issued, stall_cnt, stall_issues;
        logic fin, aborted, r, prev_v, prev_r, prev_l;
        logic [DATA_W-1:0] sum, prev_d;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        t = 1; got = 0; issued = 0; stall_cnt = 0; stall_issues = 0;
        fin = 1'b0; aborted = 1'b0; prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0;
        sum = '0; prev_d = '0;
        while (!fin && t < 400) begin
            chk("we", 32'(bus.bram_we), 32'd0);
            if (bus.bram_en) begin
                chk("addr", 32'(bus.bram_addr), 32'(issued));
                issued++;
            end
            chk("outstanding_le2", 32'((issued - got) <= 2), 32'd1);
            if (prev_v && !prev_r) begin
                chk("hold_valid", 32'(bus.w_valid), 32'd1);
                chk("hold_data",  32'(bus.w_data),  32'(prev_d));
                chk("hold_last",  32'(bus.w_last),  32'(prev_l));
            end
            if (mode == 0) begin
                chk("en_timing",    32'(bus.bram_en), 32'(t >= 1 && t <= DEPTH));
                chk("valid_timing", 32'(bus.w_valid), 32'(t >= 2 && t <= DEPTH + 1));
            end
            if (got == DEPTH) begin
                chk("done", 32'(bus.done), 32'd1);
                chk("busy_at_done", 32'(bus.busy), 32'd0);
                chk("valid_at_done", 32'(bus.w_valid), 32'd0);
                chk("issued_total", 32'(issued), 32'(DEPTH));
                if (mode == 0) chk("done_cycle", 32'(t), 32'(DEPTH + 2));
`ifdef WEIGHT_RD_CHECKSUM_EN
                chk("checksum", 32'(bus.checksum), 32'(sum));
`endif
                fin = 1'b1;
            end else begin
                chk("done_low", 32'(bus.done), 32'd0);
                chk("busy_high", 32'(bus.busy), 32'd1);
                r = 1'b1;
                if (mode == 1) r = (t % 2 == 1);
                if (mode == 2) r = ($urandom_range(0, 3) != 0);
                if (mode == 3 && bus.w_valid && got == 5 && stall_cnt < 10) begin
                    r = 1'b0;
                    chk("stall_data", 32'(bus.w_data), 32'(mem[5]));
                    if (bus.bram_en) stall_issues++;
                    stall_cnt++;
                    if (stall_cnt == 10) chk("stall_issues_le1", 32'(stall_issues <= 1), 32'd1);
                end
                if (mode == 3 && (got == 6 || got == 7)) chk("stall_follow", 32'(bus.w_valid), 32'd1);
                if (bus.w_valid) chk("last", 32'(bus.w_last), 32'(got == DEPTH - 1));
                bus.start = (mode == 1 && (t == 5 || t == 20));
                bus.w_ready = r;
                prev_v = bus.w_valid; prev_r = r; prev_d = bus.w_data; prev_l = bus.w_last;
                if (bus.w_valid && r) begin
                    chk("data", 32'(bus.w_data), 32'(mem[got]));
                    sum = sum + bus.w_data;
                    if (got == abort_at) begin
                        rst_n = 1'b0;
                        #1;
                        chk_zero("rst_async");
                        aborted = 1'b1;
                        fin = 1'b1;
                    end
                    got++;
                end
                if (!fin) begin
                    step();
                    t++;
                end
            end
        end
        bus.start = 1'b0;
        chk("pass_finished", 32'(fin), 32'd1);
        if (aborted) begin
            repeat (3) begin
                step();
                chk_zero("in_rst");
            end
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step();
                chk_zero("post_rst");
            end
        end else begin
            step();
            chk("done_pulse_end", 32'(bus.done), 32'd0);
            chk("busy_after", 32'(bus.busy), 32'd0);
            chk("valid_after", 32'(bus.w_valid), 32'd0);
`ifdef WEIGHT_RD_CHECKSUM_EN
            chk("checksum_held", 32'(bus.checksum), 32'(sum));
`endif
        end
    endtask

    initial begin
        logic [DATA_W-1:0] ref_sum;
        bus.start   = 1'b0;
        bus.w_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0100 + 16'(i);
        rst_n = 1'b0;
        repeat (3) step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();
        chk_zero("idle");

        ref_sum = '0;
        for (int i = 0; i < DEPTH; i++) ref_sum = ref_sum + mem[i];
        chk("ref_checksum_model", 32'(ref_sum), 32'h1D7A);

        run_pass(0, -1);   // full rate
        run_pass(0, -1);   // START in the cycle after DONE
        run_pass(1, -1);   // alternating ready, STARTs while busy
        run_pass(3, -1);   // stall on word 5
        run_pass(0, 12);   // reset during word-12 handshake
        run_pass(0, -1);   // restarts from address 0

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
            run_pass(2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
